// File: rtl/writeback_regfile.sv
// Writeback stage and architectural register file of the Y86-64 pipeline.
// Holds the W pipeline register, commits valE/valM to R[dstE]/R[dstM],
// serves the two combinational decode read ports, tracks the sticky
// halt/exception status and counts retired instructions.
module writeback_regfile #(
    parameter int INIT_IDENTITY = 1,
    parameter int CNT_W         = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       m_stat,
    input  logic [3:0]       m_icode,
    input  logic [63:0]      m_valE,
    input  logic [63:0]      m_valM,
    input  logic [3:0]       m_dstE,
    input  logic [3:0]       m_dstM,
    input  logic             W_stall,
    input  logic             W_bubble,
    input  logic [3:0]       d_srcA,
    input  logic [3:0]       d_srcB,
    output logic [63:0]      d_rvalA,
    output logic [63:0]      d_rvalB,
    output logic [3:0]       W_icode,
    output logic [3:0]       W_dstE,
    output logic [63:0]      W_valE,
    output logic [3:0]       W_dstM,
    output logic [63:0]      W_valM,
    output logic [2:0]       stat,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);

    localparam logic [2:0] STAT_AOK  = 3'd1;
    localparam logic [3:0] ICODE_NOP = 4'h1;
    localparam logic [3:0] REG_NONE  = 4'hF;

    // Architectural registers R0..R14; R15 does not exist.
    logic [63:0]      r_rf [0:14];

    // W pipeline register.
    logic [2:0]       r_w_stat;
    logic [3:0]       r_w_icode;
    logic [63:0]      r_w_valE;
    logic [63:0]      r_w_valM;
    logic [3:0]       r_w_dstE;
    logic [3:0]       r_w_dstM;
    logic             r_w_new;

    logic             r_halted;
    logic [CNT_W-1:0] r_retired;

    // An instruction in W is acted on exactly once: in the cycle right after
    // it was loaded from the memory stage, and only while not halted.
    logic             w_act;
    logic             w_commit;
    logic             w_fault;
    logic             w_hold;

    assign w_act    = r_w_new & ~r_halted;
    assign w_commit = w_act & (r_w_stat == STAT_AOK);
    assign w_fault  = w_act & (r_w_stat != STAT_AOK);
    // The faulting instruction is kept in W so stat keeps reporting its code.
    assign w_hold   = r_halted | w_fault | W_stall;

    // Register file: identity/zero init on reset, commit writes with valM winning.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 15; i++) begin
                r_rf[i] <= (INIT_IDENTITY != 0) ? 64'(i) : 64'd0;
            end
        end else if (w_commit) begin
            if (r_w_dstE != REG_NONE) begin
                r_rf[r_w_dstE] <= r_w_valE;
            end
            if (r_w_dstM != REG_NONE) begin
                r_rf[r_w_dstM] <= r_w_valM;
            end
        end
    end

    // W pipeline register: hold / bubble / load, with the new-instruction flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_w_stat  <= STAT_AOK;
            r_w_icode <= ICODE_NOP;
            r_w_valE  <= 64'd0;
            r_w_valM  <= 64'd0;
            r_w_dstE  <= REG_NONE;
            r_w_dstM  <= REG_NONE;
            r_w_new   <= 1'b0;
        end else if (w_hold) begin
            r_w_new   <= 1'b0;
        end else if (W_bubble) begin
            r_w_stat  <= STAT_AOK;
            r_w_icode <= ICODE_NOP;
            r_w_valE  <= 64'd0;
            r_w_valM  <= 64'd0;
            r_w_dstE  <= REG_NONE;
            r_w_dstM  <= REG_NONE;
            r_w_new   <= 1'b0;
        end else begin
            r_w_stat  <= m_stat;
            r_w_icode <= m_icode;
            r_w_valE  <= m_valE;
            r_w_valM  <= m_valM;
            r_w_dstE  <= m_dstE;
            r_w_dstM  <= m_dstM;
            r_w_new   <= 1'b1;
        end
    end

    // Sticky halt flag and retired-instruction counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_halted  <= 1'b0;
            r_retired <= '0;
        end else if (w_fault) begin
            r_halted  <= 1'b1;
        end else if (w_commit) begin
            r_retired <= r_retired + CNT_W'(1);
        end else begin
            r_retired <= r_retired;
        end
    end

    // Decode read ports: straight from the array, no write-to-read bypass.
    always_comb begin
        d_rvalA = 64'd0;
        d_rvalB = 64'd0;
        if (d_srcA != REG_NONE) begin
            d_rvalA = r_rf[d_srcA];
        end else begin
            d_rvalA = 64'd0;
        end
        if (d_srcB != REG_NONE) begin
            d_rvalB = r_rf[d_srcB];
        end else begin
            d_rvalB = 64'd0;
        end
    end

    // A bubble carries AOK, so the W status is the processor status; it is
    // frozen together with W once halted.
    assign stat    = r_w_stat;
    assign halted  = r_halted;
    assign retired = r_retired;
    assign W_icode = r_w_icode;
    assign W_dstE  = r_w_dstE;
    assign W_valE  = r_w_valE;
    assign W_dstM  = r_w_dstM;
    assign W_valM  = r_w_valM;

endmodule
